// File: rtl/metronome_beat_scheduler_if.sv
// Control/status bundle between the BPM/pattern controls and the metronome beat scheduler.
// Signal suffixes are from the scheduler's point of view.
interface metronome_beat_scheduler_if #(
    parameter int BEATS = 4
);
    logic             enable_i;
    logic [9:0]       bpm_i;
    logic [BEATS-1:0] beat_mask_i;
    logic             beat_tick_o;
    logic [1:0]       beat_idx_o;
    logic             click_o;
    logic             accent_o;
    logic             running_o;

    modport master (
        output enable_i, bpm_i, beat_mask_i,
        input  beat_tick_o, beat_idx_o, click_o, accent_o, running_o
    );

    modport slave (
        input  enable_i, bpm_i, beat_mask_i,
        output beat_tick_o, beat_idx_o, click_o, accent_o, running_o
    );
endinterface

// File: rtl/metronome_beat_scheduler.sv
// Metronome beat scheduler: phase accumulator beat ticks, 4-step click pattern, click gate.
// Optional accented downbeat (double-length click, accent_o) enabled by defining METRO_ACCENT_EN.
module metronome_beat_scheduler #(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int          ACC_W        = 32,
    parameter int          BPM_MAX      = 999,
    parameter int          BEATS        = 4,
    parameter int unsigned CLICK_CYCLES = 2500000
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    metronome_beat_scheduler_if.slave   bus
);
    // One beat per THRESH accumulated BPM units: THRESH/bpm cycles per beat, no divider.
    localparam logic [ACC_W:0] THRESH = (ACC_W+1)'(64'(CLK_HZ) * 64'd60);

`ifdef METRO_ACCENT_EN
    localparam int unsigned CLICK_MAX = 2 * CLICK_CYCLES;
`else
    localparam int unsigned CLICK_MAX = CLICK_CYCLES;
`endif
    localparam int             CNT_W     = $clog2(CLICK_MAX + 1);
    localparam logic [CNT_W-1:0] CLICK_LEN = CNT_W'(CLICK_CYCLES);
`ifdef METRO_ACCENT_EN
    localparam logic [CNT_W-1:0] ACCENT_LEN = CNT_W'(2 * CLICK_CYCLES);
`endif

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [9:0]       bpm_act_q, bpm_act_d;
    logic [1:0]       idx_q, idx_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef METRO_ACCENT_EN
    logic             accent_q, accent_d;
`endif

    logic [ACC_W:0]   sum;
    logic             wrap;
    logic [9:0]       bpm_clamped;
    logic [1:0]       idx_inc;
    logic [1:0]       tick_idx;
    logic [BEATS-1:0] hit;
    logic             sound;

    assign sum         = {1'b0, acc_q} + (ACC_W+1)'(bpm_act_q);
    assign wrap        = (sum >= THRESH);
    assign bpm_clamped = (bus.bpm_i > 10'(BPM_MAX)) ? 10'(BPM_MAX) : bus.bpm_i;
    assign idx_inc     = (idx_q == 2'(BEATS-1)) ? 2'd0 : idx_q + 2'd1;
    // Index carried by a tick issued on this edge: 0 at start, otherwise the next step.
    assign tick_idx    = (state_q == IDLE) ? 2'd0 : idx_inc;

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_hit
            assign hit[gi] = bus.beat_mask_i[gi] & (tick_idx == 2'(gi));
        end
    endgenerate
    assign sound = |hit;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            bpm_act_q <= '0;
            idx_q     <= '0;
            tick_q    <= 1'b0;
            cnt_q     <= '0;
`ifdef METRO_ACCENT_EN
            accent_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            bpm_act_q <= bpm_act_d;
            idx_q     <= idx_d;
            tick_q    <= tick_d;
            cnt_q     <= cnt_d;
`ifdef METRO_ACCENT_EN
            accent_q  <= accent_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.enable_i)  state_d = RUN;
            RUN:     if (!bus.enable_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d     = acc_q;
        bpm_act_d = bpm_act_q;
        idx_d     = idx_q;
        tick_d    = 1'b0;
        cnt_d     = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
`ifdef METRO_ACCENT_EN
        accent_d  = accent_q && (cnt_q > CNT_W'(1));
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
`ifdef METRO_ACCENT_EN
                accent_d = 1'b0;
`endif
                if (bus.enable_i) begin
                    acc_d     = '0;
                    bpm_act_d = bpm_clamped;
                    idx_d     = 2'd0;
                    tick_d    = 1'b1;
                end
            end
            RUN: begin
                if (!bus.enable_i) begin
                    acc_d = '0;
                    idx_d = 2'd0;
                    cnt_d = '0;
`ifdef METRO_ACCENT_EN
                    accent_d = 1'b0;
`endif
                end else if (wrap) begin
                    acc_d     = ACC_W'(sum - THRESH);
                    tick_d    = 1'b1;
                    idx_d     = idx_inc;
                    bpm_act_d = bpm_clamped;
                end else begin
                    acc_d = sum[ACC_W-1:0];
                end
            end
            default: ;
        endcase
        // A sounding tick (re)loads the click; a masked tick leaves any running click alone.
        if (tick_d && sound) begin
`ifdef METRO_ACCENT_EN
            if (tick_idx == 2'd0) begin
                cnt_d    = ACCENT_LEN;
                accent_d = 1'b1;
            end else begin
                cnt_d    = CLICK_LEN;
                accent_d = 1'b0;
            end
`else
            cnt_d = CLICK_LEN;
`endif
        end
    end

    assign bus.beat_tick_o = tick_q;
    assign bus.beat_idx_o  = idx_q;
    assign bus.click_o     = (cnt_q != '0);
    assign bus.running_o   = (state_q == RUN);
`ifdef METRO_ACCENT_EN
    assign bus.accent_o    = accent_q;
`else
    assign bus.accent_o    = 1'b0;
`endif
endmodule

// File: tb/tb_metronome_beat_scheduler.sv
// Scoreboard bench for metronome_beat_scheduler: driver runs a timestamp-based reference model
// and queues expected outputs per cycle; an independent monitor pops and compares.
module tb_metronome_beat_scheduler;
    localparam int THRESH = 6000;
    localparam int CLICK  = 10;

    logic clk = 1'b0;
    logic reset_i = 1'b1;

    metronome_beat_scheduler_if #(.BEATS(4)) ifc ();

    metronome_beat_scheduler #(
        .CLK_HZ(100), .ACC_W(32), .BPM_MAX(999), .BEATS(4), .CLICK_CYCLES(10)
    ) dut (
        .clock_i(clk),
        .reset_i(reset_i),
        .bus(ifc.slave)
    );

    always #5 clk = ~clk;

    // Expected {tick, idx[1:0], click, accent, running} for each cycle.
    logic [5:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: beat phase as residual + elapsed*bpm, clicks as end timestamps.
    int cyc = 0;
    bit m_run = 0, m_tick = 0;
    int m_idx = 0, m_bpm = 0, m_resid = 0, m_elapsed = 0;
    int m_click_end = 0, m_acc_end = 0;

    function automatic int clamp(input int b);
        return (b > 999) ? 999 : b;
    endfunction

    function automatic bit tick_due();
        return m_run && (m_bpm > 0) && (m_resid + (m_elapsed + 1) * m_bpm >= THRESH);
    endfunction

    task automatic do_tick(input bit [3:0] mask);
        m_tick = 1;
        if (mask[m_idx]) begin
`ifdef METRO_ACCENT_EN
            if (m_idx == 0) begin
                m_click_end = cyc + 2 * CLICK;
                m_acc_end   = cyc + 2 * CLICK;
            end else begin
                m_click_end = cyc + CLICK;
                m_acc_end   = 0;
            end
`else
            m_click_end = cyc + CLICK;
`endif
        end
    endtask

    task automatic model_step(input bit rst, input bit en, input int bpm, input bit [3:0] mask);
        cyc++;
        m_tick = 0;
        if (rst) begin
            m_run = 0; m_idx = 0; m_bpm = 0; m_resid = 0; m_elapsed = 0;
            m_click_end = 0; m_acc_end = 0;
        end else if (!m_run) begin
            if (en) begin
                m_run = 1; m_resid = 0; m_elapsed = 0; m_idx = 0;
                m_bpm = clamp(bpm);
                do_tick(mask);
            end
        end else if (!en) begin
            m_run = 0; m_idx = 0; m_click_end = 0; m_acc_end = 0;
        end else begin
            m_elapsed++;
            if (m_resid + m_elapsed * m_bpm >= THRESH) begin
                m_resid   = m_resid + m_elapsed * m_bpm - THRESH;
                m_elapsed = 0;
                m_idx     = (m_idx + 1) % 4;
                m_bpm     = clamp(bpm);
                do_tick(mask);
            end
        end
        exp_q.push_back({m_tick, 2'(m_idx), cyc < m_click_end, cyc < m_acc_end, m_run});
    endtask

    task automatic drive(input bit rst, input bit en, input int bpm, input bit [3:0] mask);
        @(negedge clk);
        reset_i         = rst;
        ifc.enable_i    = en;
        ifc.bpm_i       = 10'(bpm);
        ifc.beat_mask_i = mask;
        model_step(rst, en, bpm, mask);
    endtask

    task automatic hold(input int n, input bit en, input int bpm, input bit [3:0] mask);
        for (int i = 0; i < n; i++) drive(0, en, bpm, mask);
    endtask

    // Monitor: every cycle the DUT presents a full output set.
    initial begin
        logic [5:0] e, got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {ifc.beat_tick_o, ifc.beat_idx_o, ifc.click_o, ifc.accent_o, ifc.running_o};
                n_checks++;
                if (got === e) n_pass++;
                else $display("FAIL outputs @t=%0t tick/idx/click/accent/run got %b required %b",
                              $time, got, e);
            end
        end
    end

    initial begin
        int k;
        ifc.enable_i = 0; ifc.bpm_i = '0; ifc.beat_mask_i = '0;
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 4'b0000);
        hold(2, 0, 60, 4'b1111);

        hold(420, 1, 60, 4'b1111);
        hold(420, 1, 60, 4'b0101);
        hold(37, 1, 60, 4'b1111);
        hold(300, 1, 120, 4'b1111);
        hold(100, 1, 1023, 4'b1011);
        hold(20, 1, 60, 4'b1111);

        // Drop enable exactly on the cycle a tick is due.
        k = 0;
        while (!tick_due() && k < 300) begin
            drive(0, 1, 60, 4'b1111);
            k++;
        end
        n_checks++;
        if (tick_due()) n_pass++;
        else $display("FAIL stop_align: tick due got 0 required 1 within 300 cycles");
        drive(0, 0, 60, 4'b1111);
        hold(5, 0, 60, 4'b1111);
        hold(150, 1, 60, 4'b1111);

        // Reset while beat 2's click is sounding.
        k = 0;
        while (!(m_run && m_idx == 2 && cyc < m_click_end) && k < 400) begin
            drive(0, 1, 60, 4'b1111);
            k++;
        end
        n_checks++;
        if (m_run && m_idx == 2 && cyc < m_click_end) n_pass++;
        else $display("FAIL reset_mid_click: setup got idx %0d required 2 with click", m_idx);
        drive(1, 1, 60, 4'b1111);
        hold(3, 0, 60, 4'b1111);

        // BPM 0 pauses after the start tick; nonzero bpm not picked up until restart.
        hold(30, 1, 0, 4'b1111);
        hold(30, 1, 300, 4'b1111);
        hold(3, 0, 300, 4'b1111);

        for (int s = 0; s < 40; s++) begin
            int r, bpm, len;
            bit en, rst;
            bit [3:0] mask;
            rst  = ($urandom_range(0, 15) == 0);
            en   = ($urandom_range(0, 5) != 0);
            r    = $urandom_range(0, 9);
            bpm  = (r == 0) ? 0 : (r < 3) ? $urandom_range(1000, 1023) : $urandom_range(60, 999);
            mask = 4'($urandom_range(0, 15));
            len  = $urandom_range(5, 150);
            drive(rst, en, bpm, mask);
            hold(len, en, bpm, mask);
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: pending expectations got %0d required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/metronome_beat_scheduler.md
Name: metronome_beat_scheduler

Overview:
- Sequences the metronome click path: converts the current BPM into beat ticks with a divider-free phase accumulator, walks a 4-step beat pattern, and drives click timing.
- Sits between the BPM/beat-pattern controls and the audio DAC source-select input; the three-digit BPM display logic reads the same BPM register.
- Replaces the per-cycle divide in the top level with a single adder/comparator.

Parameters:
- CLK_HZ, 50000000, clock_i frequency in Hz; accumulator threshold THRESH = CLK_HZ*60.
- ACC_W, 32, accumulator width; must hold THRESH+BPM_MAX.
- BPM_MAX, 999, upper clamp for the active BPM.
- BEATS, 4, pattern length; width of beat_mask_i.
- CLICK_CYCLES, 2500000, click_o high time in cycles.

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  reset.
- enable_i  in  1  level; 1 = run metronome, 0 = stop.
- bpm_i  in  10  requested BPM, unsigned.
- beat_mask_i  in  BEATS  bit k=1: beat k sounds a click.
- beat_tick_o  out  1  one-cycle pulse per beat.
- beat_idx_o  out  2  index of the beat last ticked.
- click_o  out  1  click gate to the DAC source select.
- accent_o  out  1  accent flag; see Optional Feature.
- running_o  out  1  1 while in RUN.
- Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (reset_i=1 at a clock_i edge): state IDLE; acc=0, bpm_act=0, beat_idx_o=0, beat_tick_o=0, click_o=0, accent_o=0, running_o=0. Reset overrides all other inputs, including mid-click and mid-beat.
- FSM states: IDLE and RUN.
  - IDLE -> RUN when enable_i=1. On that edge: acc<=0, bpm_act<=min(bpm_i,BPM_MAX), beat_idx_o<=0, beat_tick_o<=1. The first beat is visible one cycle after enable_i is sampled high.
  - RUN -> IDLE when enable_i=0. On that edge: click_o<=0, accent_o<=0, beat_tick_o<=0, beat_idx_o<=0, acc<=0.
  - running_o=1 exactly while in RUN (registered).
- Accumulator, each cycle in RUN:
  - sum = acc + bpm_act, computed at ACC_W+1 bits.
  - If sum >= THRESH: acc<=sum-THRESH and a tick occurs. Otherwise acc<=sum.
  - Average beat period is THRESH/bpm_act cycles; exact when that value is an integer.
- On every tick, registered on that edge:
  - beat_tick_o<=1 for one cycle.
  - beat_idx_o<=(beat_idx_o+1) mod BEATS.
  - bpm_act<=min(bpm_i,BPM_MAX).
  - BPM changes therefore take effect only at beat boundaries and at start.
- Click: in the cycle beat_tick_o=1, if beat_mask_i[beat_idx_o]=1 then the click counter loads CLICK_CYCLES and click_o=1 starting that same cycle.
  - click_o stays high for exactly CLICK_CYCLES cycles.
  - A new sounding tick during an active click restarts the count; no gap or glitch on click_o.
  - A masked beat does not cut short an active click.
  - beat_mask_i is sampled at the tick only.
- bpm_act=0: acc holds, no ticks, state stays RUN. A nonzero bpm_i is not picked up until the next start. Spec'd as "BPM 0 = pause; re-enable to resume".
- bpm_i > BPM_MAX: clamped to BPM_MAX.
- Tick and enable_i=0 in the same cycle: the stop wins and no tick is issued.

Optional Feature:
- Macro: METRO_ACCENT_EN.
- Defined:
  - A sounding beat with index 0 sets accent_o=1 for its click duration.
  - Its click lasts 2*CLICK_CYCLES.
  - accent_o clears when the click ends or on stop/reset.
- Undefined:
  - accent_o is tied 0.
  - All clicks last CLICK_CYCLES.
  - No extra registers are present.

Test Plan:
- Bench setup for all cases: CLK_HZ=100 (THRESH=6000), CLICK_CYCLES=10.
- Reset mid-click (click_o=1, beat_idx_o=2) -> next cycle: all outputs 0, running_o=0, state IDLE.
- bpm_i=60, beat_mask_i=4'b1111, enable_i 0->1 -> first beat_tick_o one cycle after enable; subsequent ticks exactly 100 cycles apart; beat_idx_o sequence 0,1,2,3,0; click_o high 10 cycles per tick.
- bpm_i=60, beat_mask_i=4'b0101 -> clicks on beat_idx_o 0 and 2 only; ticks on all four beats.
- Running at 60 BPM, change bpm_i to 120 mid-beat -> the current interval stays 100 cycles; intervals after the next tick are 50 cycles. Separately, bpm_i=1023 -> bpm_act=999.
- Drop enable_i in the same cycle a tick is due -> no tick; click_o=0 next cycle; re-enable -> beat_idx_o restarts at 0.
- With METRO_ACCENT_EN defined, mask 4'b1111 -> beat 0 has click_o high 20 cycles with accent_o=1; beats 1-3 have click_o high 10 cycles with accent_o=0. Without the macro: all clicks 10 cycles, accent_o always 0.
